// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, default
// bit timing and the width helper for the per-bit cycle counter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

    // 50 MHz system clock at 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Width of a counter that must reach CLKS_PER_BIT-1
    function automatic int cnt_width(input int clks_per_bit);
        return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input pin. The reset
// value is a parameter so an idle-high line does not look active right
// after reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // shift the pin through two flops; only sync_q[1] is safe to use
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is oversampled in the system clock domain:
// the start bit is re-checked at its middle to reject glitches, data and
// stop bits are then sampled one bit period apart. Completed bytes land in
// a one-entry valid/ready holding register.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line high, waiting for a falling edge
// START     | half a bit into the start bit, confirm it is still low
// DATA      | sample 8 data bits LSB first, one bit period apart
// STOP      | sample stop bit, deliver byte / flag overrun / framing error
// WAIT_HIGH | after a framing error, wait for the line to return high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic rxs;

    uart_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk_i  (clock),
        .rst_ni (reset),
        .d_i    (io_rx),
        .q_o    (rxs)
    );

    // state, counters, shift register and holding register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
        end
    end

    // next-state logic, bit sampling and holding-register update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;

        // consumer drain; a load below in the same cycle overrides it
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end

            START: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == HALF_LAST) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d    = '0;
                        bitcnt_d = '0;
                        state_d  = DATA;
                    end
                end
            end

            DATA: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == BIT_LAST) begin
                    shift_d[bitcnt_q] = rxs;
                    cnt_d = '0;
                    if (bitcnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end
            end

            STOP: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == BIT_LAST) begin
                    if (rxs) begin
                        state_d = IDLE;
                        if (!valid_q || rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit. Expected bytes go into a queue
// as frames are sent; a negedge monitor pops and compares them on every
// rx_valid && rx_ready handshake and counts error pulses.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clock;
    logic       reset;
    logic       io_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_pass   = 0;
    int beats    = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    logic both_seen = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .io_rx     (io_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // handshake scoreboard and error-pulse counters
    always @(negedge clock) begin
        if (reset) begin
            if (frame_err) ferr_cnt++;
            if (overrun) ovr_cnt++;
            if (frame_err && overrun) both_seen = 1'b1;
            if (rx_valid && rx_ready) begin
                beats++;
                if (exp_q.size() == 0) begin
                    check("spurious_beat", {24'd0, rx_data}, 32'h100);
                end else begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // all tasks are entered and left at posedge + 1
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        io_rx = v;
        wait_cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_beats;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int b0, f0, o0, lat, tmo;
        logic [7:0] d;

        vecs[0] = '{8'h55, 1'b1, 1, 0};
        vecs[1] = '{8'hA3, 1'b1, 1, 0};
        vecs[2] = '{8'h00, 1'b1, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 0};
        vecs[4] = '{8'h0F, 1'b0, 0, 1};
        vecs[5] = '{8'hC3, 1'b1, 1, 0};

        io_rx    = 1'b1;
        rx_ready = 1'b1;
        reset    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_rx_data", {24'd0, rx_data}, 32'h0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'h0);
        check("rst_frame_err", {31'd0, frame_err}, 32'h0);
        check("rst_overrun", {31'd0, overrun}, 32'h0);
        reset = 1'b1;
        wait_cycles(5);

        // latency from io_rx fall to rx_valid, and one-cycle valid pulse
        exp_q.push_back(8'h55);
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        fork
            send_frame(8'h55, 1'b1);
            begin
                lat = 0;
                while (!rx_valid && lat < 400) begin
                    @(posedge clock);
                    #1;
                    lat++;
                end
                check("latency_55", lat, 155);
                wait_cycles(1);
                check("valid_pulse_len", {31'd0, rx_valid}, 32'h0);
            end
        join
        wait_cycles(CPB);
        check("lat_no_ferr", ferr_cnt - f0, 0);
        check("lat_no_ovr", ovr_cnt - o0, 0);

        // table of single frames with rx_ready held high
        foreach (vecs[k]) begin
            b0 = beats;
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            if (vecs[k].exp_beats != 0) exp_q.push_back(vecs[k].data);
            send_frame(vecs[k].data, vecs[k].stop);
            io_rx = 1'b1;
            wait_cycles(2 * CPB);
            check($sformatf("vec%0d_beats", k), beats - b0, vecs[k].exp_beats);
            check($sformatf("vec%0d_ferr", k), ferr_cnt - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d_ovr", k), ovr_cnt - o0, 0);
        end

        // short low glitch on an idle line, then a real frame
        b0 = beats;
        f0 = ferr_cnt;
        io_rx = 1'b0;
        wait_cycles(4);
        io_rx = 1'b1;
        wait_cycles(3 * CPB);
        check("glitch_beats", beats - b0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1);
        wait_cycles(2 * CPB);
        check("after_glitch_beats", beats - b0, 1);

        // break: stop bit low, line held low for 40 bit times
        b0 = beats;
        f0 = ferr_cnt;
        send_frame(8'h0F, 1'b0);
        wait_cycles(40 * CPB);
        io_rx = 1'b1;
        wait_cycles(2 * CPB);
        check("break_ferr", ferr_cnt - f0, 1);
        check("break_beats", beats - b0, 0);

        // overrun: consumer stalled across two frames
        rx_ready = 1'b0;
        o0 = ovr_cnt;
        f0 = ferr_cnt;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cycles(CPB);
        check("ovr_valid", {31'd0, rx_valid}, 32'h1);
        check("ovr_data_kept", {24'd0, rx_data}, 32'h11);
        check("ovr_pulses", ovr_cnt - o0, 1);
        check("ovr_no_ferr", ferr_cnt - f0, 0);
        rx_ready = 1'b1;
        wait_cycles(3);
        check("ovr_drained", {31'd0, rx_valid}, 32'h0);

        // back-to-back frames with a single stop bit
        b0 = beats;
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h80);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h80, 1'b1);
        wait_cycles(2 * CPB);
        check("b2b_beats", beats - b0, 3);
        check("b2b_ferr", ferr_cnt - f0, 0);
        check("b2b_ovr", ovr_cnt - o0, 0);

        // rx_ready raised exactly in the cycle the next byte loads
        rx_ready = 1'b0;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        wait_cycles(CPB);
        check("held_5a", {31'd0, rx_valid}, 32'h1);
        o0 = ovr_cnt;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_cycles(154);
                rx_ready = 1'b1;
                wait_cycles(1);
                rx_ready = 1'b0;
                check("same_cycle_valid", {31'd0, rx_valid}, 32'h1);
                check("same_cycle_data", {24'd0, rx_data}, 32'hA5);
            end
        join
        wait_cycles(CPB);
        check("same_cycle_no_ovr", ovr_cnt - o0, 0);
        rx_ready = 1'b1;
        wait_cycles(3);

        // reset mid-frame clears both the partial and the held byte
        rx_ready = 1'b0;
        send_frame(8'h99, 1'b1);
        wait_cycles(CPB);
        check("held_99", {31'd0, rx_valid}, 32'h1);
        d = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        io_rx = d[4];
        wait_cycles(CPB / 2);
        reset = 1'b0;
        #1;
        check("midrst_rx_data", {24'd0, rx_data}, 32'h0);
        check("midrst_rx_valid", {31'd0, rx_valid}, 32'h0);
        check("midrst_frame_err", {31'd0, frame_err}, 32'h0);
        check("midrst_overrun", {31'd0, overrun}, 32'h0);
        wait_cycles(CPB / 2);
        for (int i = 5; i < 8; i++) drive_bit(d[i]);
        drive_bit(1'b1);
        reset = 1'b1;
        wait_cycles(CPB);
        check("midrst_no_partial", {31'd0, rx_valid}, 32'h0);
        rx_ready = 1'b1;
        b0 = beats;
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        wait_cycles(2 * CPB);
        check("midrst_c3_beats", beats - b0, 1);

        tmo = 0;
        while (exp_q.size() != 0 && tmo < 1000) begin
            wait_cycles(1);
            tmo++;
        end
        check("queue_empty", exp_q.size(), 0);
        check("ferr_ovr_exclusive", {31'd0, both_seen}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the 8N1 UART line that the core's io_tx drives. It lets a host-side FPGA, or a loopback test harness, recover bytes sent by the core. It oversamples the asynchronous rx pin in the system clock domain, rejects start-bit glitches, and detects framing errors. Each received byte is presented through a one-entry valid/ready holding register, with overrun reporting.

## Interface
- CLKS_PER_BIT, default 434: system clocks per bit (50 MHz / 115200); must be ≥ 8
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- io_rx  in  1  serial line, idle high, asynchronous to clock
- rx_data  out  8  received byte, valid while rx_valid high
- rx_valid  out  1  holding register full
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low
- overrun  out  1  one-cycle pulse: completed byte dropped, holding register still full

## Operation
- io_rx passes through a 2-flop synchronizer (both flops reset to 1); `rxs` is the second flop's output.
- Bit counter `bitcnt` is 3 bits. Cycle counter `cnt` is $clog2(CLKS_PER_BIT) bits. HALF = CLKS_PER_BIT/2, using integer division.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
- IDLE: when rxs == 0, load cnt = 0 and go to START.
- START: increment cnt. When cnt == HALF-1, sample rxs:
  - rxs == 1: glitch; return to IDLE with no output.
  - rxs == 0: clear cnt and bitcnt, then go to DATA.
- DATA: increment cnt. When cnt == CLKS_PER_BIT-1, sample rxs into shift register bit `bitcnt` (LSB first) and clear cnt. After bitcnt == 7 is sampled, go to STOP; otherwise increment bitcnt.
- STOP: increment cnt. When cnt == CLKS_PER_BIT-1, sample rxs:
  - rxs == 1 with holding register empty, or being drained this cycle: load rx_data and set rx_valid. Go to IDLE.
  - rxs == 1 with holding register full and not drained: pulse overrun. Keep the old byte, discard the new one, go to IDLE.
  - rxs == 0: pulse frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until rxs == 1, then go to IDLE. This prevents a break condition from being decoded as a stream of 0x00 bytes.
- Holding register:
  - rx_valid clears on rx_valid && rx_ready unless a new byte loads in the same cycle, in which case rx_valid stays 1 with the new data.
  - rx_data is stable while rx_valid is high and not accepted.

## Timing
- Reset values: rx_data = 0x00, rx_valid = 0, frame_err = 0, overrun = 0. FSM in IDLE, synchronizer flops at 1.
- Synchronizer latency is 2 cycles from io_rx to rxs.
- Let T0 be the first cycle with rxs == 0 in IDLE. Samples are then taken at:
  - start bit: T0 + HALF
  - data bit i: T0 + HALF + (i+1)·CLKS_PER_BIT
  - stop bit: T0 + HALF + 9·CLKS_PER_BIT
- rx_valid, frame_err and overrun become visible the cycle after the stop sample.
- The FSM is in IDLE one cycle after the stop sample, so back-to-back frames with a one-bit stop are received with no gap.
- Simultaneous load and accept: new data is loaded, rx_valid stays 1, no overrun.
- Reset asserted mid-frame: the partial byte is lost and the held byte is cleared. After release, reception resumes at the next falling edge; the idle-high synchronizer reset prevents a false start.
- frame_err and overrun are never asserted in the same cycle.

## Structure
- Package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP, WAIT_HIGH)
  - constant DEFAULT_CLKS_PER_BIT = 434
  - function returning counter width for a given CLKS_PER_BIT

  A future uart_tx shares this package.
- Sub-module `sync_2ff`: 2-flop synchronizer with a reset-value parameter, reusable for other asynchronous pins.
- Target size: ~150–250 lines of RTL.

## Test plan
All scenarios use CLKS_PER_BIT = 16.
- Frame 0x55 with rx_ready = 1 → rx_valid pulses for 1 cycle with rx_data = 0x55, 2+8+144+1 = 155 cycles after io_rx falls; no error pulses.
- 4-cycle low glitch on idle io_rx → no rx_valid, no frame_err; FSM back in IDLE and the next frame 0xA3 is received correctly.
- Frame 0x0F with stop bit forced low, line held low for 40 more bit times, then released → exactly one frame_err pulse, no rx_valid, no phantom 0x00 bytes.
- rx_ready = 0, frames 0x11 then 0x22 → rx_data stays 0x11 with rx_valid = 1; one overrun pulse at the end of the second frame.
- Continuous frames 0x00, 0xFF, 0x80 with one stop bit, rx_ready = 1 → three valid beats in order, no errors. Repeat with rx_ready asserted exactly in the load cycle: no overrun.
- reset driven low at data bit 4 of frame 0x3C, released, then frame 0xC3 sent → all outputs 0 during reset; only 0xC3 is delivered.
